// File: rtl/servix_rst_seq.sv
// servix_rst_seq: ordered reset release for the servix SoC.
// Waits for PLL lock to be stable for STRETCH_CYCLES, releases the peripheral
// reset, then the core reset STAGGER_CYCLES later. Any lock loss reasserts both.
// Optional feature macro: SERVIX_RST_SEQ_LOSS_CNT_EN (adds o_loss_cnt).
module servix_rst_seq #(
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_locked,
    input  logic             i_clr_lost,
    output logic             o_rst_periph,
    output logic             o_rst,
    output logic             o_ready,
    output logic             o_lock_lost,
`ifdef SERVIX_RST_SEQ_LOSS_CNT_EN
    output logic [CNT_W-1:0] o_loss_cnt,
`endif
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_WAIT    = 3'd1,
        S_STRETCH = 3'd2,
        S_STAGGER = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rst_periph;
    logic                   r_rst;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic                   w_locked_s;
    logic                   w_loss;

    assign w_locked_s = r_sync[SYNC_STAGES-1];
    assign w_loss     = (r_state == S_RUN) && !w_locked_s;

    // Synchronize the asynchronous PLL lock into the i_clk domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
        end
    end

    // Sequencer FSM; outputs are registered alongside the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_rst_periph <= 1'b1;
            r_rst        <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state      <= S_WAIT;
                    r_cnt        <= '0;
                    r_rst_periph <= 1'b1;
                    r_rst        <= 1'b1;
                    r_ready      <= 1'b0;
                end
                S_WAIT: begin
                    r_cnt        <= '0;
                    r_rst_periph <= 1'b1;
                    r_rst        <= 1'b1;
                    r_ready      <= 1'b0;
                    if (w_locked_s) begin
                        r_state <= S_STRETCH;
                    end
                end
                S_STRETCH: begin
                    if (!w_locked_s) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == STRETCH_LAST) begin
                        r_state      <= S_STAGGER;
                        r_cnt        <= '0;
                        r_rst_periph <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STAGGER: begin
                    if (!w_locked_s) begin
                        r_state      <= S_WAIT;
                        r_cnt        <= '0;
                        r_rst_periph <= 1'b1;
                        r_rst        <= 1'b1;
                    end else if (r_cnt == STAGGER_LAST) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_rst   <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        r_state      <= S_WAIT;
                        r_cnt        <= '0;
                        r_rst_periph <= 1'b1;
                        r_rst        <= 1'b1;
                        r_ready      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_RESET;
                    r_cnt        <= '0;
                    r_rst_periph <= 1'b1;
                    r_rst        <= 1'b1;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky lock-loss flag; a new loss wins over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_lost <= 1'b0;
        end else if (w_loss) begin
            r_lock_lost <= 1'b1;
        end else if (i_clr_lost) begin
            r_lock_lost <= 1'b0;
        end
    end

`ifdef SERVIX_RST_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] r_loss_cnt;

    // Saturating lock-loss counter; a loss coinciding with a clear yields 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss) begin
            if (i_clr_lost) begin
                r_loss_cnt <= CNT_W'(1);
            end else if (r_loss_cnt != '1) begin
                r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end
        end else if (i_clr_lost) begin
            r_loss_cnt <= '0;
        end
    end

    assign o_loss_cnt = r_loss_cnt;
`endif

    assign o_rst_periph = r_rst_periph;
    assign o_rst        = r_rst;
    assign o_ready      = r_ready;
    assign o_lock_lost  = r_lock_lost;
    assign o_state      = r_state;

endmodule
